// File: rtl/y_window_monitor.sv
// Purpose: counts high samples and 0->1 rises of y over a window of window_len clk edges.
// Latency: valid rises window_len+1 edges after start is sampled (1 edge for window_len=0).
// Backpressure: the result is held (valid=1) until ack; start is ignored until back in IDLE.
module y_window_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic       y,
  input  logic       start,
  input  logic [7:0] window_len,
  input  logic       ack,
  output logic       busy,
  output logic       valid,
  output logic [7:0] rise_cnt,
  output logic [7:0] high_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OBSERVE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] rise_q, rise_d;
  logic [7:0] high_q, high_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
  logic       y_q;
  logic       rise_det;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Rise is judged against the previous edge's y, which is tracked in every
  // state so a rise on the very first window sample is still seen.
  assign rise_det = y & ~y_q;

  // Previous-sample register for rise detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y;
    end
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      rise_q      <= 8'd0;
      high_q      <= 8'd0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rise_q      <= rise_d;
      high_q      <= high_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state and counter update; flags are decoded from the next state so
  // they change on the same edge as the state itself.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rise_d      = rise_q;
    high_d      = high_q;

    case (state_q)
      ST_IDLE: begin
        // ack is meaningless here; only start matters.
        if (start) begin
          rise_d = 8'd0;
          high_d = 8'd0;
          if (window_len != 8'd0) begin
            state_d     = ST_OBSERVE;
            remaining_d = window_len;
          end else begin
            // Empty window: report zero counts right away.
            state_d     = ST_HOLD;
            remaining_d = 8'd0;
          end
        end
      end

      ST_OBSERVE: begin
        // One sample per edge; start and ack are ignored while observing.
        if (y) begin
          high_d = sat_inc(high_q);
        end
        if (rise_det) begin
          rise_d = sat_inc(rise_q);
        end
        remaining_d = remaining_q - 8'd1;
        // The sample taken with one remaining is the last of the window.
        // A zero count cannot occur here, but it is treated the same way so
        // a corrupted counter can never trap the block in OBSERVE.
        if (remaining_q <= 8'd1) begin
          state_d     = ST_HOLD;
          remaining_d = 8'd0;
        end
      end

      ST_HOLD: begin
        // Counts frozen; start is ignored even when it coincides with ack.
        if (ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        remaining_d = 8'd0;
      end
    endcase

    busy_d  = (state_d == ST_OBSERVE);
    valid_d = (state_d == ST_HOLD);
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign rise_cnt = rise_q;
  assign high_cnt = high_q;

endmodule

// File: tb/tb_y_window_monitor.sv
// Purpose: randomized scoreboard bench for y_window_monitor.
// Latency: expected results are queued at start; a monitor pops them when valid rises.
// Backpressure: the bench holds results for random cycles before acknowledging.
module tb_y_window_monitor;

  logic       clk;
  logic       reset;
  logic       y;
  logic       start;
  logic [7:0] window_len;
  logic       ack;
  logic       busy;
  logic       valid;
  logic [7:0] rise_cnt;
  logic [7:0] high_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int rise;
    int high;
    int at_cyc;
  } exp_t;

  exp_t sb[$];

  y_window_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .y          (y),
    .start      (start),
    .window_len (window_len),
    .ack        (ack),
    .busy       (busy),
    .valid      (valid),
    .rise_cnt   (rise_cnt),
    .high_cnt   (high_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time the arrival of valid.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expected result when valid rises and keeps comparing
  // the counts while valid stays high, so frozen counts are also checked.
  exp_t cur;
  bit   have_cur   = 1'b0;
  bit   valid_prev = 1'b0;

  always @(negedge clk) begin
    check("busy_valid_exclusive", int'(busy & valid), 0);
    if (valid && !valid_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 with no result pending (cycle %0d)", cyc);
        have_cur = 1'b0;
      end else begin
        cur      = sb.pop_front();
        have_cur = 1'b1;
        check("valid_latency", cyc, cur.at_cyc);
      end
    end
    if (valid && have_cur) begin
      check("rise_cnt", int'(rise_cnt), cur.rise);
      check("high_cnt", int'(high_cnt), cur.high);
    end
    if (!valid) have_cur = 1'b0;
    valid_prev = valid;
  end

  // One complete window: idle lead-in, start, samples, hold, ack.
  // mode: 0 random, 1 toggle starting at 1, 2 constant 1, 3 pattern 0,1,0,1...
  task automatic run_window(input int len, input int mode, input bit y_prev,
                            input int idle_cycles, input bit poke_start,
                            input bit start_with_ack, input int hold_cycles);
    bit w[$];
    int r;
    int h;
    bit p;

    y = y_prev;
    repeat (idle_cycles) tick();

    for (int i = 0; i < len; i++) begin
      case (mode)
        1:       w.push_back(i % 2 == 0);
        2:       w.push_back(1'b1);
        3:       w.push_back(i % 2 == 1);
        default: w.push_back(1'($urandom_range(0, 1)));
      endcase
    end

    // Reference: ones in the window, and rises against the preceding sample
    // (the value of y when start was taken for the first sample).
    r = 0;
    h = 0;
    p = y_prev;
    for (int i = 0; i < len; i++) begin
      if (w[i]) h++;
      if (w[i] && !p) r++;
      p = w[i];
    end
    if (r > 255) r = 255;
    if (h > 255) h = 255;
    sb.push_back('{rise: r, high: h, at_cyc: cyc + 1 + len});

    start      = 1'b1;
    window_len = 8'(len);
    y          = y_prev;
    tick();
    start      = 1'b0;
    window_len = 8'($urandom);
    check("busy_after_start", int'(busy), (len != 0) ? 1 : 0);
    check("valid_after_start", int'(valid), (len == 0) ? 1 : 0);

    for (int i = 0; i < len; i++) begin
      y = w[i];
      if (poke_start && i == len / 2) begin
        start      = 1'b1;
        window_len = 8'($urandom_range(1, 255));
      end
      tick();
      start = 1'b0;
      if (i < len - 1) check("busy_in_window", int'(busy), 1);
    end

    check("valid_after_window", int'(valid), 1);
    check("busy_after_window", int'(busy), 0);

    repeat (hold_cycles) begin
      y = 1'($urandom_range(0, 1));
      tick();
      check("valid_held", int'(valid), 1);
    end

    if (start_with_ack) begin
      start      = 1'b1;
      window_len = 8'($urandom_range(1, 255));
    end
    ack = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check("valid_after_ack", int'(valid), 0);
    check("busy_after_ack", int'(busy), 0);
    tick();
    check("idle_valid", int'(valid), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    y          = 1'b0;
    start      = 1'b0;
    ack        = 1'b0;
    window_len = 8'd0;
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_rise", int'(rise_cnt), 0);
    check("reset_high", int'(high_cnt), 0);
    reset = 1'b0;

    // Pattern 0,1,0,1 from y_q=0: two rises, two highs.
    run_window(4, 3, 1'b0, 1, 1'b0, 1'b0, 2);
    // y high in IDLE and throughout: no rises, three highs.
    run_window(3, 2, 1'b1, 3, 1'b0, 1'b0, 1);
    // Zero-length window.
    run_window(0, 0, 1'b0, 1, 1'b0, 1'b0, 2);
    // Full-length windows.
    run_window(255, 1, 1'b0, 1, 1'b0, 1'b0, 1);
    run_window(255, 2, 1'b0, 1, 1'b0, 1'b0, 1);

    // Reset two samples into a window of 6 abandons it.
    y          = 1'b1;
    start      = 1'b1;
    window_len = 8'd6;
    tick();
    start = 1'b0;
    y     = 1'b0;
    tick();
    y = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", int'(busy), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_rise", int'(rise_cnt), 0);
    check("midreset_high", int'(high_cnt), 0);
    // Start accepted on the first edge after reset release.
    run_window(2, 0, 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0, 1);

    // start poked during OBSERVE and start+ack together in HOLD.
    run_window(5, 0, 1'($urandom_range(0, 1)), 1, 1'b1, 1'b1, 2);

    for (int k = 0; k < 12; k++) begin
      run_window($urandom_range(0, 20), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3));
    end

    tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y_window_monitor.md
Y_WINDOW_MONITOR -- requirements
Module: y_window_monitor

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port `y`, input, 1 bit: the combinational decision output of the upstream if/else stage, sampled once per `clk` edge.
REQ-004 The block SHALL have the port `start`, input, 1 bit: request to begin an observation window; honoured only in IDLE.
REQ-005 The block SHALL have the port `window_len`, input, 8 bits: number of `y` samples in the window, unsigned; captured only when `start` is accepted.
REQ-006 The block SHALL have the port `ack`, input, 1 bit: consumer acknowledge of the result; honoured only in HOLD.
REQ-007 The block SHALL have the port `busy`, output, 1 bit: high while in OBSERVE.
REQ-008 The block SHALL have the port `valid`, output, 1 bit: high while in HOLD, meaning the result outputs are stable.
REQ-009 The block SHALL have the port `rise_cnt`, output, 8 bits: count of 0->1 transitions of `y` within the window.
REQ-010 The block SHALL have the port `high_cnt`, output, 8 bits: count of window samples with `y`==1.
REQ-011 All outputs SHALL be driven directly from flip-flops, with no combinational path from any input to any output.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, OBSERVE and HOLD.
REQ-013 In IDLE, the block SHALL go to OBSERVE next cycle when `start`=1 and `window_len`!=0, capture `remaining`=`window_len`, and clear `rise_cnt` and `high_cnt` to 0.
REQ-014 In IDLE, when `start`=1 and `window_len`=0, the block SHALL clear both counts and go directly to HOLD next cycle, reporting a zero-length window with counts 0.
REQ-015 In IDLE, the block SHALL ignore `ack`.
REQ-016 In OBSERVE, the block SHALL sample `y` on every edge, and `remaining` SHALL decrement by 1 per sample.
REQ-017 In OBSERVE, when the sample is taken with `remaining`=1, the next state SHALL be HOLD, so that exactly `window_len` samples are taken.
REQ-018 In OBSERVE, the block SHALL ignore `start` and `ack`.
REQ-019 In HOLD, the counts SHALL be frozen.
REQ-020 In HOLD, `ack`=1 SHALL return the block to IDLE next cycle, with `valid` falling on that same edge.
REQ-021 In HOLD, the block SHALL ignore `start`, including when `start` and `ack` are high in the same cycle; a new window needs `start` in IDLE.
REQ-022 A register `y_q` SHALL hold `y` from the previous edge in every state, including IDLE.
REQ-023 A rise SHALL be detected as `y`=1 and `y_q`=0, so a rise across the IDLE->OBSERVE boundary on the first window sample is counted.
REQ-024 Each OBSERVE sample with `y`=1 SHALL increment `high_cnt` by 1.
REQ-025 Each detected rise in OBSERVE SHALL increment `rise_cnt` by 1.
REQ-026 Both counters SHALL saturate at 255 and never wrap; since `window_len`<=255, `high_cnt` can reach but never exceed 255.
REQ-027 Latency from `start` acceptance to `valid`=1 SHALL be `window_len`+1 edges for `window_len`>=1, and 1 edge for `window_len`=0.
REQ-028 `busy` and `valid` SHALL never be high simultaneously.

Reset
REQ-029 When `reset`=1 at a clock edge, the block SHALL set the state to IDLE, `busy`=0, `valid`=0, `rise_cnt`=0, `high_cnt`=0, `remaining`=0 and `y_q`=0.
REQ-030 `reset` SHALL take priority over `start` and `ack`.
REQ-031 `reset` asserted mid-OBSERVE or in HOLD SHALL abandon the window, with no result reported.
REQ-032 After `reset` is released, the block SHALL accept `start` on the first edge.

Verification
REQ-033 The bench SHALL cover: `window_len`=4, `y` over window = 0,1,0,1, `y_q`=0 at start -> `valid` 5 edges after start, `rise_cnt`=2, `high_cnt`=2; then `ack` -> IDLE, `valid`=0.
REQ-034 The bench SHALL cover: `y`=1 held in IDLE, then `start` with `window_len`=3 and `y`=1 throughout -> `rise_cnt`=0, `high_cnt`=3.
REQ-035 The bench SHALL cover: `start` with `window_len`=0 -> `valid`=1 on the next edge, both counts 0, `busy` never 1.
REQ-036 The bench SHALL cover: `window_len`=255 with `y` toggling every cycle -> `high_cnt`=128 (first sample 1) and `rise_cnt`=128, with no wrap; and `y`=1 constant with `window_len`=255 -> `high_cnt`=255.
REQ-037 The bench SHALL cover: `reset` pulsed 2 cycles into an OBSERVE window of 6 -> `busy`=0, `valid`=0, counts 0 next edge; a subsequent `start` with `window_len`=2 behaves normally.
REQ-038 The bench SHALL cover: `start`=1 pulsed during OBSERVE, and `start`+`ack` together in HOLD -> no restart, counts unchanged, block in IDLE after `ack`.
